// File: rtl/pc_context_unit.sv
// pc_context_unit: program counter plus per-context saved-PC bank.
// Context 0 is the kernel; contexts 1..NCTX-1 are user programs that enter
// and leave the kernel through syscall, halt, time-slice expiry and return.
// Event inputs (halt, ctx_switch_req, ctx_return) are single-cycle
// qualifiers. They are sampled on every rising edge where stall=0 and the
// kernel is not halted; there is no handshake and nothing is queued.
module pc_context_unit #(
    parameter int ADDR_W = 32,
    parameter int NCTX = 4,
    parameter int CTX_W = 2,
    parameter int QUANTUM = 16,
    parameter logic [ADDR_W-1:0] KERNEL_BASE = '0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              halt,
    input  logic              ctx_switch_req,
    input  logic              ctx_return,
    input  logic [CTX_W-1:0]  ret_ctx,
    input  logic              preempt_en,
    input  logic              load_en,
    input  logic [CTX_W-1:0]  load_ctx,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [CTX_W-1:0]  rd_ctx,
    output logic [ADDR_W-1:0] pc,
    output logic [CTX_W-1:0]  cur_ctx,
    output logic              in_kernel,
    output logic [NCTX-1:0]   ctx_active,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [7:0]        quantum_left,
    output logic              switch_pulse,
    output logic              bad_return,
    output logic              halted
);

    localparam logic [7:0] QUANTUM_INIT = 8'(QUANTUM);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CTX_W-1:0]  ctx_q, ctx_d;
    logic [7:0]        quant_q, quant_d;
    logic              switch_q, switch_d;
    logic              bad_q, bad_d;
    logic              halted_q, halted_d;
    logic [NCTX-1:0]   active_q;
    logic [ADDR_W-1:0] saved_q [NCTX];

    // Side effects on the context bank decided by the next-state logic.
    logic              save_en;
    logic [CTX_W-1:0]  save_idx;
    logic              clr_active;

    logic ret_ok;
    logic load_ok;
    logic kernel;

    assign kernel  = (ctx_q == '0);
    // Return target is judged against the bank as it was before this edge,
    // so a same-cycle load of the target cannot make an invalid return valid.
    assign ret_ok  = (ret_ctx != '0) && (int'(ret_ctx) < NCTX) && active_q[ret_ctx];
    assign load_ok = load_en && (load_ctx != '0) && (int'(load_ctx) < NCTX);

    // Next-state selection: user-mode exits, kernel dispatch, or plain advance.
    always_comb begin
        pc_d       = pc_q;
        ctx_d      = ctx_q;
        quant_d    = quant_q;
        switch_d   = 1'b0;
        bad_d      = 1'b0;
        halted_d   = halted_q;
        save_en    = 1'b0;
        save_idx   = ctx_q;
        clr_active = 1'b0;

        if (!stall && !halted_q) begin
            if (!kernel) begin
                if (halt) begin
                    clr_active = 1'b1;
                    pc_d       = saved_q[0];
                    ctx_d      = '0;
                    quant_d    = QUANTUM_INIT;
                    switch_d   = 1'b1;
                end else if (ctx_switch_req || (preempt_en && quant_q == 8'd1)) begin
                    save_en  = 1'b1;
                    pc_d     = saved_q[0];
                    ctx_d    = '0;
                    quant_d  = QUANTUM_INIT;
                    switch_d = 1'b1;
                end else begin
                    pc_d = next_pc;
                    if (preempt_en) begin
                        quant_d = quant_q - 8'd1;
                    end
                end
            end else begin
                if (halt) begin
                    halted_d = 1'b1;
                end else if (ctx_return && ret_ok) begin
                    save_en  = 1'b1;
                    save_idx = '0;
                    pc_d     = saved_q[ret_ctx];
                    ctx_d    = ret_ctx;
                    quant_d  = QUANTUM_INIT;
                    switch_d = 1'b1;
                end else if (ctx_return) begin
                    bad_d = 1'b1;
                    pc_d  = next_pc;
                end else begin
                    pc_d = next_pc;
                end
            end
        end
    end

    // Running-context registers and one-cycle status pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q     <= KERNEL_BASE;
            ctx_q    <= '0;
            quant_q  <= QUANTUM_INIT;
            switch_q <= 1'b0;
            bad_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ctx_q    <= ctx_d;
            quant_q  <= quant_d;
            switch_q <= switch_d;
            bad_q    <= bad_d;
            halted_q <= halted_d;
        end
    end

    // Saved-PC bank and active mask; the load is written last so it wins.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NCTX; i++) begin
                saved_q[i] <= '0;
            end
            active_q <= NCTX'(1);
        end else begin
            if (save_en) begin
                saved_q[save_idx] <= next_pc;
            end
            if (clr_active) begin
                active_q[ctx_q] <= 1'b0;
            end
            if (load_ok) begin
                saved_q[load_ctx]  <= load_pc;
                active_q[load_ctx] <= 1'b1;
            end
        end
    end

    assign pc           = pc_q;
    assign cur_ctx      = ctx_q;
    assign in_kernel    = kernel;
    assign ctx_active   = active_q;
    assign rd_pc        = (int'(rd_ctx) < NCTX) ? saved_q[rd_ctx] : '0;
    assign quantum_left = quant_q;
    assign switch_pulse = switch_q;
    assign bad_return   = bad_q;
    assign halted       = halted_q;

endmodule
